uart_alici_v2: RTL and testbench
================================

UART_ALICI_V2 -- requirements
Module: uart_alici_v2

Interface
REQ-001 SHALL have parameter SAAT_BOLEN, default 5208, clock cycles per bit (legal values >= 16).
REQ-002 SHALL have parameter VERI_BIT, default 8, data bits per frame (legal values 5..8).
REQ-003 SHALL have parameter PARITE, default 0, parity mode (0 none, 1 even, 2 odd).
REQ-004 SHALL have parameter DUR_BIT, default 1, stop bits per frame (1 or 2).
REQ-005 SHALL have parameter FIFO_DERINLIK, default 4, receive FIFO entries (power of 2, >= 2).
REQ-006 SHALL have clk_g  input  1  sole clock; all logic on its rising edge.
REQ-007 SHALL have rst_g  input  1  synchronous, active-high reset.
REQ-008 SHALL have RX  input  1  asynchronous serial line, idle high.
REQ-009 SHALL have al_hazir  input  1  consumer ready; pops the FIFO head when al_gecerli is also high.
REQ-010 SHALL have tasma_temizle  input  1  clears the sticky overflow flag.
REQ-011 SHALL have al_veri  output  VERI_BIT  data at the FIFO head, LSB = first received bit.
REQ-012 SHALL have al_gecerli  output  1  FIFO not empty; head fields are valid.
REQ-013 SHALL have parite_hata  output  1  parity error flag of the head frame; always 0 when PARITE=0.
REQ-014 SHALL have cerceve_hata  output  1  framing error flag of the head frame.
REQ-015 SHALL have tasma  output  1  sticky overflow flag.
REQ-016 SHALL have mesgul  output  1  high whenever the receive FSM is not in BOSTA.

Function
REQ-017 SHALL pass RX through a two-flop synchroniser (RX_r1, RX_r2); all decisions use RX_r2.
REQ-018 SHALL run a bit counter 0..SAAT_BOLEN-1 that wraps to 0 at SAAT_BOLEN-1 in every non-BOSTA state.
REQ-019 SHALL take three samples of RX_r2 at counts (SAAT_BOLEN/16)*7, *8 and *9, using integer division, and resolve each bit by 2-of-3 majority.
REQ-020 SHALL use FSM states BOSTA, START, VERI, PARITE_AL, DUR_AL.
REQ-021 BOSTA: SHALL hold the counter at 0; RX_r2=0 SHALL move the FSM to START next cycle with the counter at 0.
REQ-022 START: at count SAAT_BOLEN-1, a majority 0 SHALL go to VERI; a majority 1 SHALL be treated as a false start: return to BOSTA, push nothing.
REQ-023 VERI: at each count SAAT_BOLEN-1, SHALL store the majority into bit index k (k = 0..VERI_BIT-1); after bit VERI_BIT-1, SHALL go to PARITE_AL if PARITE!=0, else DUR_AL.
REQ-024 PARITE_AL: SHALL store the majority as the parity bit; error = (XOR of data bits XOR parity bit) != 0 for even, == 0 for odd.
REQ-025 DUR_AL: each non-final stop bit SHALL be resolved at SAAT_BOLEN-1; the final stop bit SHALL be resolved at count (SAAT_BOLEN/16)*9+1 (early exit for resynchronisation); any stop majority 0 SHALL set the framing error.
REQ-026 On final stop resolution, SHALL go to BOSTA, reset the counter, and push {data, parite_hata, cerceve_hata} in the same cycle.
REQ-027 FIFO SHALL be show-ahead: a push to an empty FIFO SHALL give al_gecerli=1 on the next cycle with the head fields valid.
REQ-028 Pop SHALL occur when al_gecerli && al_hazir; the head SHALL advance on the next cycle.
REQ-029 Push when full without a same-cycle pop SHALL drop the frame, leave the FIFO unchanged, and set tasma.
REQ-030 Push when full with a same-cycle pop SHALL be accepted with no overflow.
REQ-031 Push and pop in the same cycle on a non-empty FIFO SHALL leave the occupancy unchanged.
REQ-032 tasma SHALL stay 1 until a cycle with tasma_temizle=1 and no new overflow; overflow SHALL win over a simultaneous clear.
REQ-033 Read and write pointers SHALL be log2(FIFO_DERINLIK)+1 bits wide with a wrap bit; full/empty SHALL be derived from them.

Reset
REQ-034 rst_g SHALL force: FSM BOSTA, counter 0, bit index 0, FIFO empty, RX_r1=RX_r2=1, al_gecerli=0, tasma=0, mesgul=0, al_veri=0, parite_hata=0, cerceve_hata=0.
REQ-035 Reset mid-frame SHALL abort the frame with no push; reception SHALL resume on the first falling edge after reset is released.

Verification (SAAT_BOLEN=16 unless stated)
REQ-036 Defaults, 8N1 frame 0xA5, al_hazir=1 -> one al_gecerli pulse, al_veri=0xA5, both error flags 0.
REQ-037 PARITE=1, frame 0x03 with parity bit 1 -> al_veri=0x03, parite_hata=1; repeated with parity bit 0 -> parite_hata=0.
REQ-038 RX low for 3 cycles, then high -> no push, FSM returns to BOSTA, mesgul falls after 16 cycles.
REQ-039 Frame 0x55 with stop bit 0 -> cerceve_hata=1, al_veri=0x55; with DUR_BIT=2 and only the second stop bit 0 -> cerceve_hata=1.
REQ-040 FIFO_DERINLIK=2, al_hazir=0, three frames 0x11, 0x22, 0x33 -> tasma=1; pops return 0x11 then 0x22; tasma_temizle -> tasma=0.
REQ-041 rst_g asserted during data bit 4 -> no push; next frame 0x7E is received correctly.

Source files
------------

// File: rtl/uart_alici_v2.sv
// uart_alici_v2: oversampled UART receiver with 2-of-3 majority bit
// decisions, optional parity, 1 or 2 stop bits and a show-ahead receive FIFO.
module uart_alici_v2 #(
  parameter int SAAT_BOLEN    = 5208,
  parameter int VERI_BIT      = 8,
  parameter int PARITE        = 0,
  parameter int DUR_BIT       = 1,
  parameter int FIFO_DERINLIK = 4
) (
  input  logic                clk_g,
  input  logic                rst_g,
  input  logic                RX,
  input  logic                al_hazir,
  input  logic                tasma_temizle,
  output logic [VERI_BIT-1:0] al_veri,
  output logic                al_gecerli,
  output logic                parite_hata,
  output logic                cerceve_hata,
  output logic                tasma,
  output logic                mesgul
);

  localparam int SW = $clog2(SAAT_BOLEN);
  localparam int BW = $clog2(VERI_BIT);
  localparam int AW = $clog2(FIFO_DERINLIK);
  localparam int FW = VERI_BIT + 2;

  localparam logic [SW-1:0] SAYAC_SON = SW'(SAAT_BOLEN - 1);
  localparam logic [SW-1:0] ORNEK_1   = SW'((SAAT_BOLEN / 16) * 7);
  localparam logic [SW-1:0] ORNEK_2   = SW'((SAAT_BOLEN / 16) * 8);
  localparam logic [SW-1:0] ORNEK_3   = SW'((SAAT_BOLEN / 16) * 9);
  localparam logic [SW-1:0] DUR_ERKEN = SW'((SAAT_BOLEN / 16) * 9 + 1);
  localparam logic [SW-1:0] SAYAC_BIR = SW'(1);
  localparam logic [BW-1:0] BIT_SON   = BW'(VERI_BIT - 1);
  localparam logic [BW-1:0] BIT_BIR   = BW'(1);
  localparam logic          DUR_SON   = (DUR_BIT == 2);
  localparam logic [AW:0]   PTR_BIR   = (AW + 1)'(1);

  localparam logic [2:0] BOSTA     = 3'd0;
  localparam logic [2:0] START     = 3'd1;
  localparam logic [2:0] VERI      = 3'd2;
  localparam logic [2:0] PARITE_AL = 3'd3;
  localparam logic [2:0] DUR_AL    = 3'd4;

  logic                RX_r1, RX_r2;
  logic [2:0]          durum;
  logic [SW-1:0]       sayac;
  logic [BW-1:0]       bit_idx;
  logic                dur_idx;
  logic [2:0]          ornek;
  logic [VERI_BIT-1:0] veri_r;
  logic                par_hata_r, cer_hata_r;
  logic                cogunluk, bit_sonu;
  logic                yaz, yaz_kabul, oku, tasma_olay;
  logic [FW-1:0]       yaz_kelime;

  logic [FW-1:0]       bellek [FIFO_DERINLIK];
  logic [AW:0]         yaz_ptr, oku_ptr;
  logic                bos, dolu;
  logic [FW-1:0]       bas;

  // Two-flop synchroniser for the asynchronous serial line, idle high.
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      RX_r1 <= 1'b1;
      RX_r2 <= 1'b1;
    end else begin
      RX_r1 <= RX;
      RX_r2 <= RX_r1;
    end
  end

  assign cogunluk = (ornek[0] & ornek[1]) | (ornek[0] & ornek[2]) | (ornek[1] & ornek[2]);
  assign bit_sonu = (sayac == SAYAC_SON);
  // The final stop bit is resolved early so the next start edge is not missed.
  assign yaz = (durum == DUR_AL) && (dur_idx == DUR_SON) && (sayac == DUR_ERKEN);
  assign yaz_kelime = {veri_r, (PARITE != 0) && par_hata_r, cer_hata_r | ~cogunluk};
  assign mesgul = (durum != BOSTA);

  // Receive FSM: bit-period counter, mid-bit sampling and frame assembly.
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      durum      <= BOSTA;
      sayac      <= '0;
      bit_idx    <= '0;
      dur_idx    <= 1'b0;
      ornek      <= '1;
      veri_r     <= '0;
      par_hata_r <= 1'b0;
      cer_hata_r <= 1'b0;
    end else begin
      if (durum != BOSTA) begin
        if (sayac == ORNEK_1) ornek[0] <= RX_r2;
        if (sayac == ORNEK_2) ornek[1] <= RX_r2;
        if (sayac == ORNEK_3) ornek[2] <= RX_r2;
      end

      if (durum == BOSTA || yaz || bit_sonu)
        sayac <= '0;
      else
        sayac <= sayac + SAYAC_BIR;

      case (durum)
        BOSTA: begin
          if (!RX_r2) begin
            durum      <= START;
            bit_idx    <= '0;
            dur_idx    <= 1'b0;
            par_hata_r <= 1'b0;
            cer_hata_r <= 1'b0;
          end
        end
        START: begin
          if (bit_sonu) durum <= cogunluk ? BOSTA : VERI;
        end
        VERI: begin
          if (bit_sonu) begin
            veri_r[bit_idx] <= cogunluk;
            if (bit_idx == BIT_SON) begin
              bit_idx <= '0;
              durum   <= (PARITE != 0) ? PARITE_AL : DUR_AL;
            end else begin
              bit_idx <= bit_idx + BIT_BIR;
            end
          end
        end
        PARITE_AL: begin
          if (bit_sonu) begin
            par_hata_r <= (PARITE == 2) ? ~(^veri_r ^ cogunluk) : (^veri_r ^ cogunluk);
            durum      <= DUR_AL;
          end
        end
        DUR_AL: begin
          if (yaz) begin
            durum <= BOSTA;
          end else if (bit_sonu && dur_idx != DUR_SON) begin
            if (!cogunluk) cer_hata_r <= 1'b1;
            dur_idx <= 1'b1;
          end
        end
        default: durum <= BOSTA;
      endcase
    end
  end

  assign bos        = (yaz_ptr == oku_ptr);
  assign dolu       = (yaz_ptr[AW] != oku_ptr[AW]) && (yaz_ptr[AW-1:0] == oku_ptr[AW-1:0]);
  assign oku        = !bos && al_hazir;
  assign yaz_kabul  = yaz && (!dolu || oku);
  assign tasma_olay = yaz && dolu && !oku;

  // FIFO pointers with wrap bit; a pop frees the slot for a same-cycle push.
  always_ff @(posedge clk_g) begin
    if (rst_g) begin
      yaz_ptr <= '0;
      oku_ptr <= '0;
    end else begin
      if (yaz_kabul) yaz_ptr <= yaz_ptr + PTR_BIR;
      if (oku)       oku_ptr <= oku_ptr + PTR_BIR;
    end
  end

  // FIFO storage; contents are masked at the outputs while empty.
  always_ff @(posedge clk_g) begin
    if (yaz_kabul) bellek[yaz_ptr[AW-1:0]] <= yaz_kelime;
  end

  // Sticky overflow flag; a new overflow wins over a clear.
  always_ff @(posedge clk_g) begin
    if (rst_g)              tasma <= 1'b0;
    else if (tasma_olay)    tasma <= 1'b1;
    else if (tasma_temizle) tasma <= 1'b0;
  end

  assign bas          = bellek[oku_ptr[AW-1:0]];
  assign al_gecerli   = !bos;
  assign al_veri      = bos ? '0 : bas[FW-1:2];
  assign parite_hata  = !bos && bas[1];
  assign cerceve_hata = !bos && bas[0];

endmodule

// File: tb/tb_uart_alici_v2.sv
// Directed bench for uart_alici_v2: four instances cover 8N1, even parity,
// two stop bits and a two-entry FIFO, each with its own serial line.
module tb_uart_alici_v2;

  logic clk_g = 1'b0;
  always #5 clk_g = ~clk_g;

  logic [3:0] rst, rx, hazir, temizle;
  logic [7:0] v0, v1, v2, v3;
  logic g0, g1, g2, g3, ph0, ph1, ph2, ph3, ch0, ch1, ch2, ch3;
  logic t0, t1, t2, t3, m0, m1, m2, m3;

  int checks = 0;
  int errors = 0;

  // Instance 0 always ready: every received frame shows as a one-cycle pulse.
  int         n0 = 0;
  logic [7:0] cv0 = '0;
  logic       cp0 = 1'b0, cc0 = 1'b0;

  uart_alici_v2 #(.SAAT_BOLEN(16)) u0 (
    .clk_g(clk_g), .rst_g(rst[0]), .RX(rx[0]), .al_hazir(hazir[0]), .tasma_temizle(temizle[0]),
    .al_veri(v0), .al_gecerli(g0), .parite_hata(ph0), .cerceve_hata(ch0), .tasma(t0), .mesgul(m0));

  uart_alici_v2 #(.SAAT_BOLEN(16), .PARITE(1)) u1 (
    .clk_g(clk_g), .rst_g(rst[1]), .RX(rx[1]), .al_hazir(hazir[1]), .tasma_temizle(temizle[1]),
    .al_veri(v1), .al_gecerli(g1), .parite_hata(ph1), .cerceve_hata(ch1), .tasma(t1), .mesgul(m1));

  uart_alici_v2 #(.SAAT_BOLEN(16), .DUR_BIT(2)) u2 (
    .clk_g(clk_g), .rst_g(rst[2]), .RX(rx[2]), .al_hazir(hazir[2]), .tasma_temizle(temizle[2]),
    .al_veri(v2), .al_gecerli(g2), .parite_hata(ph2), .cerceve_hata(ch2), .tasma(t2), .mesgul(m2));

  uart_alici_v2 #(.SAAT_BOLEN(16), .FIFO_DERINLIK(2)) u3 (
    .clk_g(clk_g), .rst_g(rst[3]), .RX(rx[3]), .al_hazir(hazir[3]), .tasma_temizle(temizle[3]),
    .al_veri(v3), .al_gecerli(g3), .parite_hata(ph3), .cerceve_hata(ch3), .tasma(t3), .mesgul(m3));

  always @(negedge clk_g) begin
    if (g0) begin
      n0  = n0 + 1;
      cv0 = v0;
      cp0 = ph0;
      cc0 = ch0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic bekle(input int n);
    repeat (n) @(posedge clk_g);
    #1;
  endtask

  task automatic tx_bit(input int w, input logic b);
    rx[w] = b;
    bekle(16);
  endtask

  task automatic tx_frame(input int w, input logic [7:0] d, input bit par_var, input logic par,
                          input logic s1, input bit iki_dur, input logic s2);
    tx_bit(w, 1'b0);
    for (int i = 0; i < 8; i++) tx_bit(w, d[i]);
    if (par_var) tx_bit(w, par);
    tx_bit(w, s1);
    if (iki_dur) tx_bit(w, s2);
    rx[w] = 1'b1;
    bekle(30);
  endtask

  task automatic pop(input int w);
    hazir[w] = 1'b1;
    bekle(1);
    hazir[w] = 1'b0;
  endtask

  initial begin
    logic [7:0] kesik;
    rst     = '1;
    rx      = '1;
    hazir   = 4'b0001;
    temizle = '0;
    bekle(3);

    // Reset state
    check("rst_gecerli", g0, 0);
    check("rst_tasma", t0, 0);
    check("rst_mesgul", m0, 0);
    check("rst_veri", v0, 0);
    check("rst_parite", ph0, 0);
    check("rst_cerceve", ch0, 0);
    rst = '0;
    bekle(5);

    // 8N1 frame 0xA5, consumer ready
    tx_frame(0, 8'hA5, 0, 1'b0, 1'b1, 0, 1'b0);
    check("a5_pulses", n0, 1);
    check("a5_veri", cv0, 8'hA5);
    check("a5_parite", cp0, 0);
    check("a5_cerceve", cc0, 0);
    check("a5_popped", g0, 0);

    // False start: 3 cycles low
    rx[0] = 1'b0;
    bekle(3);
    check("fs_mesgul_up", m0, 1);
    rx[0] = 1'b1;
    bekle(15);
    check("fs_mesgul_held", m0, 1);
    bekle(1);
    check("fs_mesgul_down", m0, 0);
    bekle(10);
    check("fs_no_push", n0, 1);

    // Framing error: stop bit 0
    tx_frame(0, 8'h55, 0, 1'b0, 1'b0, 0, 1'b0);
    bekle(20);
    check("fe_pulses", n0, 2);
    check("fe_veri", cv0, 8'h55);
    check("fe_cerceve", cc0, 1);
    check("fe_parite", cp0, 0);

    // Even parity: 0x03 with parity 1 is an error, parity 0 is clean
    tx_frame(1, 8'h03, 1, 1'b1, 1'b1, 0, 1'b0);
    check("par1_gecerli", g1, 1);
    check("par1_veri", v1, 8'h03);
    check("par1_hata", ph1, 1);
    check("par1_cerceve", ch1, 0);
    pop(1);
    check("par1_popped", g1, 0);
    tx_frame(1, 8'h03, 1, 1'b0, 1'b1, 0, 1'b0);
    check("par0_gecerli", g1, 1);
    check("par0_veri", v1, 8'h03);
    check("par0_hata", ph1, 0);
    pop(1);

    // Two stop bits: clean, then second stop bit 0
    tx_frame(2, 8'h3C, 0, 1'b0, 1'b1, 1, 1'b1);
    check("d2_ok_gecerli", g2, 1);
    check("d2_ok_veri", v2, 8'h3C);
    check("d2_ok_cerceve", ch2, 0);
    pop(1 + 1);
    tx_frame(2, 8'h55, 0, 1'b0, 1'b1, 1, 1'b0);
    check("d2_bad_gecerli", g2, 1);
    check("d2_bad_veri", v2, 8'h55);
    check("d2_bad_cerceve", ch2, 1);

    // Two-entry FIFO overflow and sticky flag
    tx_frame(3, 8'h11, 0, 1'b0, 1'b1, 0, 1'b0);
    tx_frame(3, 8'h22, 0, 1'b0, 1'b1, 0, 1'b0);
    check("ov_full_no_tasma", t3, 0);
    tx_frame(3, 8'h33, 0, 1'b0, 1'b1, 0, 1'b0);
    check("ov_tasma", t3, 1);
    check("ov_head0", v3, 8'h11);
    pop(3);
    check("ov_head1", v3, 8'h22);
    check("ov_gecerli1", g3, 1);
    check("ov_sticky", t3, 1);
    pop(3);
    check("ov_empty", g3, 0);
    temizle[3] = 1'b1;
    bekle(1);
    temizle[3] = 1'b0;
    check("ov_cleared", t3, 0);

    // Reset during data bit 4 aborts the frame
    kesik = 8'h5A;
    tx_bit(0, 1'b0);
    for (int i = 0; i < 4; i++) tx_bit(0, kesik[i]);
    rx[0] = kesik[4];
    bekle(5);
    rst[0] = 1'b1;
    bekle(1);
    check("mr_mesgul_rst", m0, 0);
    bekle(10);
    for (int i = 5; i < 8; i++) tx_bit(0, kesik[i]);
    tx_bit(0, 1'b1);
    bekle(5);
    rst[0] = 1'b0;
    bekle(30);
    check("mr_no_push", n0, 2);
    tx_frame(0, 8'h7E, 0, 1'b0, 1'b1, 0, 1'b0);
    check("mr_next_pulses", n0, 3);
    check("mr_next_veri", cv0, 8'h7E);
    check("mr_next_cerceve", cc0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
